vin_freq_counter: RTL and testbench



---
 rtl/vin_freq_counter.sv | 141 ++++++++++++++
 tb/tb_vin_freq_counter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vin_freq_counter.sv
// vin_freq_counter: frequency-measuring VIN channel.
// Counts rising edges of one asynchronous VIN pin over a fixed gate window of
// GATE_CYCLES clk cycles and publishes the saturating count as processVariable,
// with a one-cycle update strobe and a sticky overflow flag per window.
// Optional build macro VIN_FILTER_EN inserts a FILTER_LEN-sample glitch filter
// between the synchroniser and the edge detector.
module vin_freq_counter #(
   parameter int WIDTH       = 16,
   parameter int GATE_CYCLES = 4800000,
   parameter int FILTER_LEN  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             vin,
   output logic [WIDTH-1:0] processVariable,
   output logic             update,
   output logic             overflow
);

   localparam int               GC_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GC_W-1:0]  GC_LAST = GC_W'(GATE_CYCLES - 1);
   localparam logic [WIDTH-1:0] EC_MAX  = {WIDTH{1'b1}};

   logic             r_s1;
   logic             r_s2;
   logic             r_lvl_d;
   logic             w_lvl;
   logic             w_edge;
   logic             w_term;
   logic [GC_W-1:0]  r_gc;
   logic [WIDTH-1:0] r_ec;
   logic             r_sat;
   logic [WIDTH-1:0] w_pv_next;
   logic             w_ov_next;

   // Two-flop synchroniser for the asynchronous VIN pin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= vin;
         r_s2 <= r_s1;
      end
   end

`ifdef VIN_FILTER_EN
   localparam int              FC_W    = $clog2(FILTER_LEN + 1);
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_LEN - 1);

   logic [FC_W-1:0] r_fc;
   logic            r_flt;

   // Accept a new level only after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fc  <= {FC_W{1'b0}};
         r_flt <= 1'b0;
      end else if (r_s2 == r_flt) begin
         r_fc  <= {FC_W{1'b0}};
      end else if (r_fc == FC_LAST) begin
         r_flt <= r_s2;
         r_fc  <= {FC_W{1'b0}};
      end else begin
         r_fc  <= r_fc + FC_W'(1);
      end
   end

   assign w_lvl = r_flt;
`else
   // FILTER_LEN only matters for the filtered build.
   localparam int filter_len_unused = FILTER_LEN;

   assign w_lvl = r_s2;
`endif

   // Previous level for rising-edge detection; runs regardless of enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lvl_d <= 1'b0;
      end else begin
         r_lvl_d <= w_lvl;
      end
   end

   assign w_edge = w_lvl & ~r_lvl_d;
   assign w_term = (r_gc == GC_LAST);

   // Closing value of the window: an edge on the terminal cycle still counts.
   always_comb begin
      w_pv_next = r_ec;
      w_ov_next = r_sat;
      if (w_edge) begin
         if (r_ec == EC_MAX) begin
            w_ov_next = 1'b1;
         end else begin
            w_pv_next = r_ec + WIDTH'(1);
         end
      end else begin
         w_ov_next = r_sat;
      end
   end

   // Gate counter, edge counter and published result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gc            <= {GC_W{1'b0}};
         r_ec            <= {WIDTH{1'b0}};
         r_sat           <= 1'b0;
         processVariable <= {WIDTH{1'b0}};
         overflow        <= 1'b0;
         update          <= 1'b0;
      end else if (!enable) begin
         r_gc            <= {GC_W{1'b0}};
         r_ec            <= {WIDTH{1'b0}};
         r_sat           <= 1'b0;
         processVariable <= {WIDTH{1'b0}};
         overflow        <= 1'b0;
         update          <= 1'b0;
      end else if (w_term) begin
         r_gc            <= {GC_W{1'b0}};
         r_ec            <= {WIDTH{1'b0}};
         r_sat           <= 1'b0;
         processVariable <= w_pv_next;
         overflow        <= w_ov_next;
         update          <= 1'b1;
      end else begin
         r_gc            <= r_gc + GC_W'(1);
         update          <= 1'b0;
         if (w_edge) begin
            if (r_ec == EC_MAX) begin
               r_sat <= 1'b1;
            end else begin
               r_ec  <= r_ec + WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_vin_freq_counter.sv
// Randomised and directed bench for vin_freq_counter (WIDTH=4, GATE_CYCLES=100).
// A reference model counts rising edges of the (delayed, optionally filtered)
// sampled input with unbounded integers and clamps at window close.
module tb_vin_freq_counter;

   localparam int WIDTH = 4;
   localparam int GATE  = 100;
   localparam int FL    = 4;
   localparam int MAXV  = (1 << WIDTH) - 1;
`ifdef VIN_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic             clk    = 1'b0;
   logic             rst_n  = 1'b0;
   logic             enable = 1'b0;
   logic             vin    = 1'b0;
   logic [WIDTH-1:0] pv;
   logic             upd;
   logic             ov;

   vin_freq_counter #(
      .WIDTH       (WIDTH),
      .GATE_CYCLES (GATE),
      .FILTER_LEN  (FL)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .enable          (enable),
      .vin             (vin),
      .processVariable (pv),
      .update          (upd),
      .overflow        (ov)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input int exp);
      n_cmp++;
      if (act !== 32'(exp)) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit vh[$];      // sampled vin values still in the two-stage pipe
   bit uq[$];      // last FL synchronised samples (filter window)
   bit m_flt;
   bit m_lvl_prev;
   int m_cnt;
   int m_pos;
   int m_pv;
   bit m_ov;
   bit m_upd;

   function automatic void model_reset();
      vh.delete();
      vh.push_back(1'b0);
      vh.push_back(1'b0);
      uq.delete();
      m_flt      = 1'b0;
      m_lvl_prev = 1'b0;
      m_cnt      = 0;
      m_pos      = 0;
      m_pv       = 0;
      m_ov       = 1'b0;
      m_upd      = 1'b0;
   endfunction

   // Effect of one clock edge that samples vin=v, enable=e.
   function automatic void model_step(input bit v, input bit e);
      bit u;
      bit lvl;
      bit all_diff;
      bit edge_b;
      vh.push_back(v);
      u   = vh.pop_front();
      lvl = FILT ? m_flt : u;
      if (FILT) begin
         uq.push_back(u);
         if (uq.size() > FL) void'(uq.pop_front());
         all_diff = (uq.size() == FL);
         foreach (uq[i]) if (uq[i] == m_flt) all_diff = 1'b0;
         if (all_diff) m_flt = u;
      end
      edge_b     = lvl && !m_lvl_prev;
      m_lvl_prev = lvl;
      if (e) begin
         m_cnt += int'(edge_b);
         m_pos++;
         if (m_pos == GATE) begin
            m_pv  = (m_cnt > MAXV) ? MAXV : m_cnt;
            m_ov  = (m_cnt > MAXV);
            m_upd = 1'b1;
            m_cnt = 0;
            m_pos = 0;
         end else begin
            m_upd = 1'b0;
         end
      end else begin
         m_cnt = 0;
         m_pos = 0;
         m_pv  = 0;
         m_ov  = 1'b0;
         m_upd = 1'b0;
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic drive_step(input bit v, input bit e);
      check_val("pv",  32'(pv),  m_pv);
      check_val("ov",  32'(ov),  int'(m_ov));
      check_val("upd", 32'(upd), int'(m_upd));
      vin    = v;
      enable = e;
      model_step(v, e);
   endtask

   task automatic cycle(input bit v, input bit e);
      @(negedge clk);
      drive_step(v, e);
   endtask

   task automatic run_square(input int n, input int period, input int high, input bit e);
      for (int k = 0; k < n; k++) cycle(bit'((k % period) < high), e);
   endtask

   task automatic run_random(input int n);
      int dens_tab[4] = '{3, 10, 30, 60};
      int dens;
      int off_left;
      bit rv;
      bit re;
      rv       = 1'b0;
      off_left = 0;
      dens     = dens_tab[$urandom_range(3)];
      for (int k = 0; k < n; k++) begin
         if (k % 300 == 0) dens = dens_tab[$urandom_range(3)];
         if ($urandom_range(99) < dens) rv = !rv;
         if (off_left > 0) begin
            off_left--;
            re = 1'b0;
         end else if ($urandom_range(299) == 0) begin
            off_left = $urandom_range(20, 1);
            re = 1'b0;
         end else begin
            re = 1'b1;
         end
         cycle(rv, re);
      end
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check_val("rst_pv",  32'(pv),  0);
      check_val("rst_ov",  32'(ov),  0);
      check_val("rst_upd", 32'(upd), 0);
      rst_n = 1'b1;
      drive_step(1'b0, 1'b1);

      // Idle: enabled, vin low.
      repeat (249) cycle(1'b0, 1'b1);
      check_val("idle_pv", 32'(pv), 0);

      // Period-10 square wave.
      run_square(300, 10, 5, 1'b1);
      check_val("sq10_pv", 32'(pv), 10);
      check_val("sq10_ov", 32'(ov), 0);

      // Period-4 wave: saturates unfiltered; 2-cycle highs are filtered out.
      run_square(300, 4, 2, 1'b1);
      check_val("sat_pv", 32'(pv), FILT ? 0 : 15);
      check_val("sat_ov", 32'(ov), FILT ? 0 : 1);

      run_square(250, 10, 5, 1'b1);
      check_val("unsat_pv", 32'(pv), 10);
      check_val("unsat_ov", 32'(ov), 0);

      // Enable dropped mid-window, then re-raised.
      run_square(40, 10, 5, 1'b1);
      run_square(37, 10, 5, 1'b0);
      check_val("en_low_pv",  32'(pv),  0);
      check_val("en_low_upd", 32'(upd), 0);
      run_square(250, 10, 5, 1'b1);
      check_val("reen_pv", 32'(pv), 10);

      // Short glitches and longer pulses.
      run_square(300, 20, 2, 1'b1);
      check_val("glitch_pv", 32'(pv), FILT ? 0 : 5);
      run_square(300, 20, 6, 1'b1);
      check_val("pulse6_pv", 32'(pv), 5);

      run_random(1500);

      // Asynchronous reset between clock edges, mid-window.
      run_square(30, 10, 5, 1'b1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_pv",  32'(pv),  0);
      check_val("arst_ov",  32'(ov),  0);
      check_val("arst_upd", 32'(upd), 0);
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      drive_step(1'b0, 1'b1);
      run_square(250, 10, 5, 1'b1);
      check_val("post_rst_pv", 32'(pv), 10);

      run_random(600);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
